spi_receive: RTL
================

SPI_RECEIVE -- requirements
Module: spi_receive

Interface
REQ-001 Parameter DATA_W, default 8, bits per received word.
REQ-002 Parameter SYNC_STAGES, default 2, flip-flop depth of input synchronizers (min 2).
REQ-003 clk  input  1  system clock, 100 MHz; all logic on posedge clk only.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 sck  input  1  SPI serial clock from remote master, asynchronous to clk; idles high; max frequency clk/8.
REQ-006 cs  input  1  chip select, active low, asynchronous.
REQ-007 mosi  input  1  serial data, MSB first, stable around sck rising edge.
REQ-008 rx_data  output  DATA_W  last completed word.
REQ-009 rx_valid  output  1  rx_data holds an unconsumed word.
REQ-010 rx_ready  input  1  consumer accepts rx_data when rx_valid & rx_ready on a clk edge.
REQ-011 rx_busy  output  1  high while FSM is in ACTIVE.
REQ-012 frame_err  output  1  one-cycle pulse: cs deasserted with partial word.
REQ-013 overrun  output  1  one-cycle pulse: word completed while holding register full and not drained.

Function
REQ-014 sck, cs, mosi SHALL each pass through SYNC_STAGES flip-flops before use; same depth on all three so data stays aligned with the clock edge.
REQ-015 A rising sck event SHALL be one clk cycle where synced sck is 1 and its registered previous value is 0; falling sck edges SHALL be ignored.
REQ-016 FSM states: IDLE, ARMED, ACTIVE (encodings in shared package).
REQ-017 IDLE -> ARMED when synced cs is 1; ARMED -> ACTIVE when synced cs is 0; ACTIVE -> ARMED when synced cs returns to 1.
REQ-018 sck events SHALL be ignored outside ACTIVE.
REQ-019 In ACTIVE, each sck event SHALL shift synced mosi into the LSB of the shift register and increment a bit counter of width clog2(DATA_W)+1.
REQ-020 On the DATA_W-th event, the counter SHALL wrap to 0, and the assembled word SHALL be presented per REQ-022..024; FSM stays ACTIVE for multi-word frames.
REQ-021 Latency: rx_valid SHALL rise exactly SYNC_STAGES+2 clk cycles after the clk edge that first samples the final sck rising edge at the pin.
REQ-022 Holding register empty, or rx_ready high in the same cycle: rx_data loads the new word, rx_valid = 1.
REQ-023 Holding register full and rx_ready low: new word dropped, rx_data unchanged, overrun pulses for 1 cycle.
REQ-024 rx_valid & rx_ready with no new word: rx_valid clears next cycle; rx_data holds its value.
REQ-025 cs rising in ACTIVE with bit counter != 0: frame_err pulses 1 cycle, partial word discarded, counter cleared, no rx_valid.
REQ-026 cs rising with counter == 0: no error, counter stays 0.
REQ-027 cs toggling in IDLE SHALL produce no output activity other than the transition to ARMED.

Reset
REQ-028 While rst is high: FSM = IDLE, counter = 0, shift register = 0, rx_data = 0, rx_valid = 0, rx_busy = 0, frame_err = 0, overrun = 0.
REQ-029 Synchronizer flops SHALL reset to idle line levels: sck = 1, cs = 1, mosi = 0.
REQ-030 Reset released mid-frame (cs low): block SHALL wait in IDLE until cs is seen high, so it never captures a misaligned word.

Structure
REQ-031 Shared package spi_pkg SHALL hold the FSM state typedef and default DATA_W, for reuse by the transmit side.
REQ-032 One sub-module, spi_sync (parameterised depth, reset value), SHALL be instantiated once per input line.

Verification
REQ-033 Reset, cs low, send 0xA5 at sck = clk/40 -> one rx_valid with rx_data = 0xA5, exactly SYNC_STAGES+2 cycles after the last sck rise; frame_err = overrun = 0.
REQ-034 One cs-low frame carrying 0x3C, 0xC3, with rx_ready tied high -> two rx_valid events with data 0x3C then 0xC3; rx_busy high throughout the frame.
REQ-035 cs raised after 5 bits of 0xFF -> one frame_err pulse, no rx_valid; next full frame 0x81 -> rx_data = 0x81.
REQ-036 rx_ready low while receiving 0x11 then 0x22 -> rx_data stays 0x11, one overrun pulse; later rx_ready pulse -> rx_valid clears.
REQ-037 rst asserted after bit 3 and released while cs still low, then 4 more bits -> no rx_valid; next cs-high/low frame 0x5A -> rx_data = 0x5A.
REQ-038 sck toggled with cs high -> no rx_valid, no frame_err; rx_busy stays 0.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding and default word width,
// so the receive and transmit sides stay consistent.
package spi_pkg;

  localparam int unsigned DefaultDataW = 8;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StArmed  = 2'd1,
    StActive = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous input line, with a
// selectable reset level so each line resets to its idle state.
module spi_sync #(
  parameter int unsigned Depth    = 2,
  parameter logic        ResetVal = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [Depth-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {Depth{ResetVal}};
    end else begin
      sync_q <= {sync_q[Depth-2:0], d_i};
    end
  end

  assign q_o = sync_q[Depth-1];

endmodule

// File: rtl/spi_receive.sv
// SPI receive slave (mode 3, MSB first) sampled in the clk domain, with a
// single-entry holding register and valid/ready hand-off to the consumer.
module spi_receive
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W      = DefaultDataW,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck,
  input  logic              cs,
  input  logic              mosi,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_busy,
  output logic              frame_err,
  output logic              overrun
);

  localparam int unsigned CntW   = $clog2(DATA_W) + 1;
  localparam int unsigned FlushW = $clog2(SYNC_STAGES + 1);

  logic sck_s, cs_s, mosi_s;

  spi_sync #(.Depth(SYNC_STAGES), .ResetVal(1'b1)) u_sync_sck (
    .clk (clk),
    .rst (rst),
    .d_i (sck),
    .q_o (sck_s)
  );

  spi_sync #(.Depth(SYNC_STAGES), .ResetVal(1'b1)) u_sync_cs (
    .clk (clk),
    .rst (rst),
    .d_i (cs),
    .q_o (cs_s)
  );

  spi_sync #(.Depth(SYNC_STAGES), .ResetVal(1'b0)) u_sync_mosi (
    .clk (clk),
    .rst (rst),
    .d_i (mosi),
    .q_o (mosi_s)
  );

  spi_state_e        state_q, state_d;
  logic              sck_prev_q, rise_q, mosi_q;
  logic [FlushW-1:0] flush_q;
  logic              primed;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;

  // The cs synchronizer holds its reset level for SYNC_STAGES cycles after reset;
  // ignore it until real pin values have flushed through so a mid-frame reset
  // release cannot look like a cs-high and arm a misaligned capture.
  assign primed = (flush_q == FlushW'(SYNC_STAGES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_q    <= '0;
      sck_prev_q <= 1'b1;
      rise_q     <= 1'b0;
      mosi_q     <= 1'b0;
    end else begin
      if (!primed) flush_q <= flush_q + FlushW'(1);
      sck_prev_q <= sck_s;
      rise_q     <= sck_s & ~sck_prev_q;
      mosi_q     <= mosi_s;
    end
  end

  always_comb begin
    state_d     = state_q;
    frame_err_d = 1'b0;
    unique case (state_q)
      StIdle:   if (primed && cs_s) state_d = StArmed;
      StArmed:  if (!cs_s) state_d = StActive;
      StActive: begin
        if (cs_s) begin
          state_d     = StArmed;
          frame_err_d = (cnt_q != '0);
        end
      end
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (state_q == StActive) begin
      if (cs_s) begin
        shift_d = '0;
        cnt_d   = '0;
      end else if (rise_q) begin
        shift_d = {shift_q[DATA_W-2:0], mosi_q};
        if (cnt_q == CntW'(DATA_W - 1)) begin
          cnt_d  = '0;
          done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
    end
  end

  // A completing word and a same-cycle consume can coexist: old word leaves, new loads.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = 1'b0;
    if (done_q) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      shift_q     <= '0;
      done_q      <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      done_q      <= done_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_busy   = (state_q == StActive);
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule
